// File: rtl/mode_stopwatch_lap.sv
// mode_stopwatch_lap: BCD stopwatch with start/pause, clear and a circular lap buffer,
// rendered as 32 LCD character cells through a registered index/out port.
module mode_stopwatch_lap #(
    parameter int LAP_DEPTH = 4,
    parameter int MAX_MIN   = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_100hz,
    input  logic [3:0] sw_in,
    input  logic [4:0] index,
    output logic [7:0] out,
    output logic       running,
    output logic [4:0] lap_count
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    localparam logic [3:0]   MT   = 4'(MAX_MIN / 10);
    localparam logic [3:0]   MO   = 4'(MAX_MIN % 10);
    localparam logic [127:0] STOP = "Stop Watch      ";
    state_t      state, state_nx;
    logic [3:0]  sw_prev, sw_rise;
    logic [23:0] tm, tm_nx, lap_tm;
    logic [23:0] lap_buf [16];
    logic [3:0]  wr_ptr, sel_idx, vt, vo;
    logic [4:0]  view_sel, vn;
    logic [5:0]  sel_raw;
    logic [7:0]  ch;
    logic        do_clr, do_lap, do_next, do_tick, cc_w, ss_w, mm_w;

    function automatic logic [3:0] inc(input logic [3:0] d, input logic [3:0] top);
        return d == top ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [7:0] dig(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    assign sw_rise = sw_in & ~sw_prev;

    // Clear dominates; a captured lap suppresses next-lap in the same cycle.
    always_comb begin
        do_clr  = sw_rise[2];
        do_lap  = sw_rise[1] && state == RUN && !do_clr;
        do_next = sw_rise[3] && !do_clr && !do_lap && lap_count != 5'd0;
        do_tick = en_100hz && state == RUN && !do_clr;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_comb
        state_nx = do_clr ? IDLE : !sw_rise[0] ? state : state == RUN ? PAUSE : RUN;

    always_comb
        running = state == RUN;

    always_comb begin
        cc_w  = tm[7:4] == 4'd9 && tm[3:0] == 4'd9;
        ss_w  = tm[15:12] == 4'd5 && tm[11:8] == 4'd9;
        mm_w  = tm[23:20] == MT && tm[19:16] == MO;
        tm_nx = tm;
        tm_nx[3:0]   = inc(tm[3:0], 4'd9);
        tm_nx[7:4]   = tm[3:0] == 4'd9 ? inc(tm[7:4], 4'd9) : tm[7:4];
        tm_nx[11:8]  = cc_w ? inc(tm[11:8], 4'd9) : tm[11:8];
        tm_nx[15:12] = cc_w && tm[11:8] == 4'd9 ? inc(tm[15:12], 4'd5) : tm[15:12];
        tm_nx[19:16] = !(cc_w && ss_w) ? tm[19:16] : mm_w ? 4'd0 : inc(tm[19:16], 4'd9);
        tm_nx[23:20] = !(cc_w && ss_w) ? tm[23:20] : mm_w ? 4'd0 :
                       tm[19:16] == 4'd9 ? tm[23:20] + 4'd1 : tm[23:20];
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sw_prev   <= '0;
            tm        <= '0;
            wr_ptr    <= '0;
            lap_count <= '0;
            view_sel  <= '0;
        end else begin
            sw_prev <= sw_in;
            if (do_clr) begin
                tm        <= '0;
                wr_ptr    <= '0;
                lap_count <= '0;
                view_sel  <= '0;
            end else begin
                if (do_tick) tm <= tm_nx;
                if (do_lap) begin
                    wr_ptr    <= wr_ptr == 4'(LAP_DEPTH - 1) ? 4'd0 : wr_ptr + 4'd1;
                    lap_count <= lap_count == 5'(LAP_DEPTH) ? lap_count : lap_count + 5'd1;
                    view_sel  <= '0;
                end else if (do_next)
                    view_sel <= view_sel + 5'd1 == lap_count ? 5'd0 : view_sel + 5'd1;
            end
        end

    always_ff @(posedge clk)
        if (do_lap) lap_buf[wr_ptr] <= tm;

    // view_sel counts back from the newest entry, which sits just behind wr_ptr.
    always_comb begin
        sel_raw = 6'(wr_ptr) + 6'(LAP_DEPTH) - 6'd1 - 6'(view_sel);
        sel_idx = 4'(sel_raw >= 6'(LAP_DEPTH) ? sel_raw - 6'(LAP_DEPTH) : sel_raw);
        lap_tm  = lap_buf[sel_idx];
        vn      = view_sel + 5'd1;
        vt      = vn >= 5'd10 ? 4'd1 : 4'd0;
        vo      = 4'(vn >= 5'd10 ? vn - 5'd10 : vn);
    end

    always_comb begin
        ch = " ";
        if (!index[4]) begin
            if (lap_count == 5'd0) ch = STOP[8 * (15 - int'(index[3:0])) +: 8];
            else
                case (index[3:0])
                    4'd0:  ch = "L";
                    4'd1:  ch = "A";
                    4'd2:  ch = "P";
                    4'd3:  ch = dig(vt);
                    4'd4:  ch = dig(vo);
                    4'd6:  ch = dig(lap_tm[23:20]);
                    4'd7:  ch = dig(lap_tm[19:16]);
                    4'd8:  ch = ":";
                    4'd9:  ch = dig(lap_tm[15:12]);
                    4'd10: ch = dig(lap_tm[11:8]);
                    4'd11: ch = ":";
                    4'd12: ch = dig(lap_tm[7:4]);
                    4'd13: ch = dig(lap_tm[3:0]);
                    default: ch = " ";
                endcase
        end else
            case (index[3:0])
                4'd0:  ch = "T";
                4'd1:  ch = "I";
                4'd2:  ch = "M";
                4'd3:  ch = "E";
                4'd5:  ch = dig(tm[23:20]);
                4'd6:  ch = dig(tm[19:16]);
                4'd7:  ch = ":";
                4'd8:  ch = dig(tm[15:12]);
                4'd9:  ch = dig(tm[11:8]);
                4'd10: ch = ":";
                4'd11: ch = dig(tm[7:4]);
                4'd12: ch = dig(tm[3:0]);
                4'd14: ch = state == RUN ? "R" : state == PAUSE ? "P" : " ";
                default: ch = " ";
            endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) out <= '0;
        else      out <= ch;
endmodule

// File: tb/tb_mode_stopwatch_lap.sv
// tb_mode_stopwatch_lap: scoreboard bench; a centisecond/queue model predicts every cell,
// running and lap_count, and a negedge monitor checks the DUT against it.
module tb_mode_stopwatch_lap;
    localparam int D   = 4;
    localparam int MM  = 1;
    localparam int WRAP = (MM + 1) * 6000;

    logic       clk = 0, rst = 0, en_100hz = 0;
    logic [3:0] sw_in = 0;
    logic [4:0] index = 0;
    logic [7:0] out;
    logic       running;
    logic [4:0] lap_count;

    mode_stopwatch_lap #(.LAP_DEPTH(D), .MAX_MIN(MM)) dut (
        .clk(clk), .rst(rst), .en_100hz(en_100hz), .sw_in(sw_in),
        .index(index), .out(out), .running(running), .lap_count(lap_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] o; logic r; logic [4:0] lc; logic [4:0] idx;} exp_t;
    exp_t q[$];
    int checks = 0, failures = 0, ncyc = 0;

    // Model: time in plain centiseconds, laps newest-first; st 0=idle 1=run 2=pause.
    int t = 0, st = 0, view = 0;
    int laps[$];
    logic [3:0] prev = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, ncyc, act, exp);
        end
    endtask

    function automatic logic [7:0] model_char(input logic [4:0] idx);
        string s;
        int lt;
        byte stc;
        stc = st == 1 ? "R" : st == 2 ? "P" : " ";
        if (idx >= 16)
            s = $sformatf("TIME %02d:%02d:%02d %c ", t / 6000, (t / 100) % 60, t % 100, stc);
        else if (laps.size() == 0)
            s = "Stop Watch      ";
        else begin
            lt = laps[view];
            s = $sformatf("LAP%02d %02d:%02d:%02d  ", view + 1, lt / 6000, (lt / 100) % 60, lt % 100);
        end
        return s.getc(int'(idx[3:0]));
    endfunction

    task automatic model_step(input logic [3:0] sw, input logic tick);
        logic [3:0] rise;
        rise = sw & ~prev;
        prev = sw;
        if (rise[2]) begin
            t = 0; st = 0; view = 0; laps.delete();
        end else begin
            if (rise[1] && st == 1) begin
                laps.push_front(t);
                if (laps.size() > D) void'(laps.pop_back());
                view = 0;
            end else if (rise[3] && laps.size() > 0)
                view = (view + 1) % laps.size();
            if (tick && st == 1) t = (t + 1) % WRAP;
            if (rise[0]) st = st == 1 ? 2 : 1;
        end
    endtask

    task automatic cycle(input logic [3:0] sw, input logic tick, input logic [4:0] idx);
        exp_t e;
        sw_in = sw; en_100hz = tick; index = idx;
        e.o = model_char(idx);
        e.idx = idx;
        model_step(sw, tick);
        e.r = st == 1;
        e.lc = 5'(laps.size());
        @(posedge clk); #1;
        ncyc++;
        q.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(4'd0, 1'b1, 5'($urandom));
    endtask

    task automatic read_line(input int base);
        for (int i = 0; i < 16; i++) cycle(4'd0, 1'b0, 5'(base + i));
    endtask

    // Asynchronous reset mid-run: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        @(negedge clk); #1;
        sw_in = 0; en_100hz = 0; rst = 0; #1;
        chk("async_rst_out", int'(out), 0);
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_lap_count", int'(lap_count), 0);
        @(posedge clk); #1;
        rst = 1;
        t = 0; st = 0; view = 0; prev = 0; laps.delete();
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("out[idx%0d]", e.idx), int'(out), int'(e.o));
            chk("running", int'(running), int'(e.r));
            chk("lap_count", int'(lap_count), int'(e.lc));
        end

    initial begin
        logic [3:0] lv;
        #2;
        chk("reset_out", int'(out), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_lap_count", int'(lap_count), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        read_line(0);
        read_line(16);
        cycle(4'd1, 1'b1, 5'd30);
        cycle(4'd0, 1'b0, 5'd30);
        ticks(6000);
        read_line(16);
        ticks(5999);
        read_line(16);
        cycle(4'd0, 1'b1, 5'd21);
        read_line(16);
        ticks(122);
        cycle(4'd2, 1'b1, 5'd0);
        read_line(0);
        for (int k = 0; k < 4; k++) begin
            ticks(37);
            cycle(4'd2, 1'b0, 5'd0);
            cycle(4'd0, 1'b0, 5'd0);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(4'd8, 1'b0, 5'd3);
            read_line(0);
        end
        cycle(4'd1, 1'b1, 5'd30);
        cycle(4'd0, 1'b1, 5'd28);
        cycle(4'd1, 1'b1, 5'd28);
        cycle(4'd0, 1'b0, 5'd28);
        cycle(4'd10, 1'b1, 5'd4);
        read_line(0);
        cycle(4'd1, 1'b0, 5'd30);
        cycle(4'd2, 1'b0, 5'd0);
        cycle(4'd0, 1'b0, 5'd30);
        cycle(4'd4, 1'b0, 5'd0);
        cycle(4'd1, 1'b0, 5'd0);
        cycle(4'd0, 1'b0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            ticks(11);
            cycle(4'd2, 1'b0, 5'd0);
            cycle(4'd0, 1'b0, 5'd0);
        end
        cycle(4'd5, 1'b1, 5'd30);
        read_line(0);
        read_line(16);
        lv = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                do_reset();
                lv = 0;
            end
            lv[0] = lv[0] ^ ($urandom_range(0, 5) == 0);
            lv[1] = lv[1] ^ ($urandom_range(0, 3) == 0);
            lv[3] = lv[3] ^ ($urandom_range(0, 3) == 0);
            lv[2] = $urandom_range(0, 60) == 0;
            cycle(lv, 1'($urandom_range(0, 1)), 5'($urandom));
        end
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mode_stopwatch_lap.md
# mode_stopwatch_lap

Parametrised stopwatch display mode with start/pause, clear, and a lap buffer of configurable depth. It counts centiseconds on the shared 100 Hz enable in BCD, captures lap snapshots into a circular buffer, and drives the 32-cell character LCD through the same index/out interface as the other display modes. It sits beside the other mode blocks behind the mode multiplexer feeding the LCD controller.

## Interface
- LAP_DEPTH, 4, number of stored laps; legal 1..16
- MAX_MIN, 59, highest minute value before wrap; legal 1..99
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en_100hz  in  1  one-clk-wide tick at 100 Hz
- sw_in  in  4  debounced, synchronised button levels; [0] start/pause, [1] lap, [2] clear, [3] next-lap view
- index  in  5  LCD cell address; 0..15 line 1, 16..31 line 2
- out  out  8  ASCII code for cell `index`
- running  out  1  high in RUN state
- lap_count  out  5  number of valid laps stored, 0..LAP_DEPTH

## Operation
- Reset values: out=8'h00, running=0, lap_count=0, time=00:00:00, view_sel=0, write pointer=0, state IDLE, edge-detect history=0.
- Buttons: internal rising-edge detect per bit (previous level register); one action per 0->1 transition; held level does nothing further.
- Time held as six BCD digits mm:ss:cc; no binary-to-BCD conversion.
- FSM: IDLE --start--> RUN; RUN --start--> PAUSE; PAUSE --start--> RUN; any state --clear--> IDLE.
- Count: only in RUN on en_100hz. cc 00..99; cc 99 -> 00 with ss+1; ss 59 -> 00 with mm+1; MAX_MIN:59:99 -> 00:00:00, keeps running.
- Lap (RUN only; ignored in IDLE/PAUSE): current time is written at the write pointer, pointer advances mod LAP_DEPTH, lap_count saturates at LAP_DEPTH. When full, the oldest entry is overwritten. view_sel is reset to 0 (newest).
- Next-lap: view_sel = (view_sel+1) mod lap_count; ignored when lap_count==0. view_sel 0 = newest, lap_count-1 = oldest.
- Clear: time, lap_count, write pointer and view_sel go to 0; the state goes to IDLE. Buffer contents need not be erased.
- Simultaneous events, same clk:
  - Clear overrides every other button and the tick.
  - Start plus tick: the tick counts only if the pre-edge state is RUN. IDLE->RUN does not count that tick; RUN->PAUSE does.
  - Lap plus tick: the snapshot is the pre-increment time.
  - Lap plus start in RUN: the lap is captured, then the state goes to PAUSE.
  - Lap plus next-lap: the lap wins and view_sel=0.
- Display line 1, lap_count==0: "Stop Watch" followed by 6 spaces.
- Display line 1, lap_count>0, cells 0..15: "LAP", tens and ones of (view_sel+1) in decimal, ' ', mm, ':', ss, ':', cc of the selected lap, then two spaces.
- Display line 2, cells 16..31: "TIME ", mm (cells 21-22), ':', ss (24-25), ':', cc (27-28), ' ', then a state char at cell 30 ('R' in RUN, 'P' in PAUSE, ' ' in IDLE), then ' '.
- Digits are output as 8'h30 + BCD.

## Timing
- out is registered: it reflects `index` sampled at edge N, valid after edge N. The content shown is the state before edge N.
- running follows the state register with no extra latency.
- A button rising edge acts at the first clk edge that samples the level high.
- Time registers update at the clk edge where en_100hz=1 and the state is RUN.
- Lap write and lap_count update at the edge that detects lap. The new entry is readable through out from the next index sample.
- rst assertion at any time forces all reset values immediately, including mid-count and mid-lap.

## Test plan
- Reset, press start, apply 6000 ticks -> index 21..28 read "01:00:00"; running=1; index 30 = 8'h52.
- MAX_MIN=59, preload by counting to 59:59:99, one more tick -> "00:00:00"; state stays RUN.
- RUN, lap at 00:01:23 with a tick in the same clk -> index 6..13 = "00:01:23"; lap_count=1; index 0..4 = "LAP01".
- LAP_DEPTH=4, take 5 laps -> lap_count=4; view_sel 3 (after 3 next presses) shows lap 2's time; a 4th next press wraps view to "LAP01".
- Start and stop: press start while PAUSE with a tick in the same cycle -> that tick is not counted. Press lap in PAUSE -> lap_count unchanged.
- Clear while RUN with lap_count=3, and start asserted in the same cycle -> IDLE; time 00:00:00; lap_count=0; line 1 = "Stop Watch"; running=0.
